// File: rtl/load_store_unit.sv
// Load/store unit: converts core byte/half/word accesses into word-wide Memory transactions.
// Optional build macro LSU_ALIGN_CHECK_EN rejects misaligned halfword/word requests.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           rdata_o,
    output logic                  mem_rd_en_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic [31:0]           mem_data_i,
    input  logic                  mem_ack_i
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [1:0]            lane_q, lane_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_data_q, mem_data_d;

    logic accept;
    logic misalign;
    logic bad_req;

    // Replace only the addressed lane of the fetched word.
    function automatic logic [31:0] merge_word(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic [15:0] wd);
        logic [31:0] r;
        r = w;
        case (sz)
            SIZE_BYTE: begin
                case (lane)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lane[1]) r[31:16] = wd;
                else         r[15:0]  = wd;
            end
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            SIZE_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SIZE_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default:   r = w;
        endcase
        return r;
    endfunction

    assign accept = (state_q == IDLE) && req_i;

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign = ((size_i == SIZE_HALF) && addr_i[0]) ||
                      ((size_i == SIZE_WORD) && (addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign bad_req = (size_i == SIZE_RSVD) || misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (bad_req)                              state_d = RESP;
                    else if (we_i && (size_i == SIZE_WORD))   state_d = WR_REQ;
                    else                                      state_d = RD_REQ;
                end
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: if (mem_ack_i) state_d = we_q ? WR_REQ : RESP;
            WR_REQ:  state_d = WR_WAIT;
            WR_WAIT: if (mem_ack_i) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; strobes/flags follow the state being entered.
    always_comb begin
        we_d        = we_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == RESP);
        err_d       = accept && bad_req;
        mem_rd_en_d = (state_d == RD_REQ);
        mem_wr_en_d = (state_d == WR_REQ);

        if (accept) begin
            we_d       = we_i;
            size_d     = size_i;
            unsigned_d = unsigned_i;
            lane_d     = addr_i[1:0];
            wdata_d    = wdata_i[15:0];
            mem_addr_d = {addr_i[ADDR_WIDTH-1:2], 2'b00};
            if (!bad_req && we_i && (size_i == SIZE_WORD)) mem_data_d = wdata_i;
        end

        if ((state_q == RD_WAIT) && mem_ack_i) begin
            if (we_q) mem_data_d = merge_word(mem_data_i, size_q, lane_q, wdata_q);
            else      rdata_d    = extend_load(mem_data_i, size_q, lane_q, unsigned_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= 32'd0;
        end else begin
            we_q        <= we_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_rd_en_o = mem_rd_en_q;
    assign mem_wr_en_o = mem_wr_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;

endmodule
